// File: rtl/scaledquantser_pkg.sv
// Shared constants, types and config-clamp helpers for the quantizer/serializer.
package scaledquantser_pkg;
  localparam int BP   = 45;                // product width from the scaler
  localparam int BMAX = 16;                // maximum output precision
  localparam int BI   = $clog2(BP);        // width of msb index
  localparam int BQ   = $clog2(BMAX + 1);  // width of precision field

  typedef logic signed [BP-1:0] p_type;
  typedef logic [BMAX-1:0]      q_type;

  typedef enum logic [1:0] {IDLE, QUANT, SHIFT} state_e;

  // Precision 0 means 1 bit; anything above BMAX is capped.
  function automatic logic [BQ-1:0] clamp_prec(input logic [BQ-1:0] p);
    if (p == '0) return BQ'(1);
    if (p > BQ'(BMAX)) return BQ'(BMAX);
    return p;
  endfunction

  // MSB index cannot point past the top bit of the product.
  function automatic logic [BI-1:0] clamp_msb(input logic [BI-1:0] m);
    if (m > BI'(BP - 1)) return BI'(BP - 1);
    return m;
  endfunction
endpackage

// File: rtl/scaledquantser_roundsat.sv
// Combinational window select, round-half-up and saturate of one product.
// q_o holds the result right-aligned in the low prec bits (two's complement
// when signed_i). Config is clamped here so the block is safe to reuse alone.
module fxp_roundsat
  import scaledquantser_pkg::*;
(
  input  p_type         data_i,
  input  logic [BI-1:0] msb_i,
  input  logic [BQ-1:0] prec_i,
  input  logic          signed_i,
  output q_type         q_o,
  output logic          sat_o
);
  localparam int LW = BI + 1;
  typedef logic signed [BP:0] w_t;   // one guard bit so the rounding add never wraps
  localparam w_t ONE = w_t'(1);

  logic [BQ-1:0] prec;
  logic [LW-1:0] msb1, lsb;
  w_t            ext, rnd, hi, lo;

  // Round at the window LSB, then clamp to the representable output range.
  always_comb begin
    prec  = clamp_prec(prec_i);
    msb1  = LW'(clamp_msb(msb_i)) + LW'(1);
    lsb   = (msb1 > LW'(prec)) ? msb1 - LW'(prec) : '0;
    ext   = {data_i[BP-1], data_i};
    rnd   = ext;
    if (lsb != '0) rnd = (ext + (ONE << (lsb - LW'(1)))) >>> lsb;

    if (signed_i) begin
      hi = (ONE << (prec - BQ'(1))) - ONE;
      lo = -(ONE << (prec - BQ'(1)));
    end else begin
      hi = (ONE << prec) - ONE;
      lo = '0;
    end

    sat_o = 1'b0;
    q_o   = rnd[BMAX-1:0];
    if (rnd > hi) begin
      q_o   = hi[BMAX-1:0];
      sat_o = 1'b1;
    end else if (rnd < lo) begin
      q_o   = lo[BMAX-1:0];
      sat_o = 1'b1;
    end
  end
endmodule

// File: rtl/scaledquantser.sv
// Quantizer/serializer: latch a product and its config, round/saturate it
// in one cycle, then shift it out MSB first on a valid/ready bit stream.
module scaledquantser
  import scaledquantser_pkg::*;
(
  input  logic          clk_i,
  input  logic          clr_i,
  input  p_type         in_data_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [BI-1:0] cfg_msbidx_i,
  input  logic [BQ-1:0] cfg_prec_i,
  input  logic          cfg_signed_i,
  output logic          out_bit_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          out_last_o,
  output logic          out_sat_o
);
  state_e        state_q, state_d;
  p_type         data_q, data_d;
  logic [BI-1:0] msb_q, msb_d;
  logic [BQ-1:0] prec_q, prec_d;   // held already clamped
  logic [BQ-1:0] cnt_q, cnt_d;     // bits remaining after the current one
  logic          sgn_q, sgn_d;
  logic          sat_q, sat_d;
  q_type         sreg_q, sreg_d;
  q_type         q;
  logic          q_sat;

  fxp_roundsat u_roundsat (
    .data_i   (data_q),
    .msb_i    (msb_q),
    .prec_i   (prec_q),
    .signed_i (sgn_q),
    .q_o      (q),
    .sat_o    (q_sat)
  );

  // Next-state and stream outputs; every output is gated by state so reset
  // (which forces IDLE asynchronously) zeroes them at once.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    msb_d       = msb_q;
    prec_d      = prec_q;
    sgn_d       = sgn_q;
    sat_d       = sat_q;
    cnt_d       = cnt_q;
    sreg_d      = sreg_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_o = ~clr_i;
        if (in_valid_i) begin
          data_d  = in_data_i;
          msb_d   = clamp_msb(cfg_msbidx_i);
          prec_d  = clamp_prec(cfg_prec_i);
          sgn_d   = cfg_signed_i;
          state_d = QUANT;
        end
      end
      QUANT: begin
        // Left-align so the word MSB sits at the shift-out position.
        sreg_d  = q << (BQ'(BMAX) - prec_q);
        cnt_d   = prec_q - BQ'(1);
        sat_d   = q_sat;
        state_d = SHIFT;
      end
      SHIFT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          sreg_d = sreg_q << 1;
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - BQ'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    out_bit_o  = out_valid_o & sreg_q[BMAX-1];
    out_last_o = out_valid_o & (cnt_q == '0);
    out_sat_o  = out_valid_o & sat_q;
  end

  // State and datapath registers; reset drops any word in flight.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      msb_q   <= '0;
      prec_q  <= BQ'(1);
      sgn_q   <= 1'b0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      msb_q   <= msb_d;
      prec_q  <= prec_d;
      sgn_q   <= sgn_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
    end
  end
endmodule
